// File: rtl/corescore_uart_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART emitter among NUM_SRC
// byte streams, holding each grant until end-of-message or an idle timeout.
module corescore_uart_arbiter #(
  parameter int         NUM_SRC  = 4,
  parameter logic [7:0] EOM_BYTE = 8'h0A,
  parameter int         TIMEOUT  = 1024,
  localparam int        GW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int        CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*NUM_SRC-1:0] i_tdata,
  input  logic [NUM_SRC-1:0]   i_tvalid,
  output logic [NUM_SRC-1:0]   o_tready,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [GW-1:0]        o_grant_id,
  output logic                 o_busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic [CW-1:0] r_count;

  logic [7:0]    w_src_data;
  logic          w_src_valid;
  logic          w_xfer;
  logic          w_eom;
  logic          w_timeout;
  logic          w_found;
  logic [GW-1:0] w_sel;

  assign w_src_data  = i_tdata[{r_grant, 3'b000} +: 8];
  assign w_src_valid = i_tvalid[r_grant];
  assign w_xfer      = (r_state == LOCKED) && w_src_valid && i_ready;
  assign w_eom       = w_xfer && (w_src_data == EOM_BYTE);
  assign w_timeout   = (TIMEOUT > 0) && (r_count == CW'(TIMEOUT - 1)) && !w_src_valid;

  // Search starts just after the last grant, so the previous owner is tried last.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_grant;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!w_found && i_tvalid[(int'(r_grant) + i) % NUM_SRC]) begin
        w_found = 1'b1;
        w_sel   = GW'((int'(r_grant) + i) % NUM_SRC);
      end
    end
  end

  assign o_data     = w_src_data;
  assign o_valid    = (r_state == LOCKED) && w_src_valid;
  assign o_busy     = (r_state == LOCKED);
  assign o_grant_id = r_grant;

  always_comb begin
    o_tready = '0;
    if (r_state == LOCKED) begin
      o_tready[r_grant] = i_ready;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_grant <= GW'(NUM_SRC - 1);
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_found) begin
            r_state <= LOCKED;
            r_grant <= w_sel;
          end
        end
        LOCKED: begin
          if (w_eom || w_timeout) begin
            r_state <= IDLE;
          end
          // Stalling on i_ready with valid high keeps the counter cleared.
          if (TIMEOUT == 0 || w_src_valid) begin
            r_count <= '0;
          end else if (r_count != CW'(TIMEOUT - 1)) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_uart_arbiter.sv
// Directed self-checking bench for corescore_uart_arbiter with four sources
// and a short idle timeout.
module tb_corescore_uart_arbiter;

  localparam int NUM_SRC = 4;
  localparam int TIMEOUT = 8;
  localparam int GW      = 2;

  logic                 clk;
  logic                 rst;
  logic [8*NUM_SRC-1:0] tdata;
  logic [NUM_SRC-1:0]   tvalid;
  logic [NUM_SRC-1:0]   tready;
  logic [7:0]           data;
  logic                 valid;
  logic                 ready;
  logic [GW-1:0]        grantId;
  logic                 busy;

  int checkCount = 0;
  int failCount  = 0;

  corescore_uart_arbiter #(
    .NUM_SRC (NUM_SRC),
    .EOM_BYTE(8'h0A),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tdata   (tdata),
    .i_tvalid  (tvalid),
    .o_tready  (tready),
    .o_data    (data),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_grant_id(grantId),
    .o_busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int src, input logic [7:0] d, input logic v);
    tdata[8*src +: 8] = d;
    tvalid[src]       = v;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    tdata  = '0;
    tvalid = '0;
    ready  = 1'b1;

    // Test 1: reset state, then "AB\n" from source 0
    doReset();
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_tready", 32'(tready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(grantId), 32'd3);
    applyStimulus(0, 8'h41, 1'b1);
    checkOutput("t1_decide_valid", 32'(valid), 32'd0);
    checkOutput("t1_decide_tready", 32'(tready), 32'd0);
    nextCycle();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_grant", 32'(grantId), 32'd0);
    checkOutput("t1_data_A", 32'(data), 32'h41);
    checkOutput("t1_valid", 32'(valid), 32'd1);
    checkOutput("t1_tready", 32'(tready), 32'b0001);
    nextCycle();
    applyStimulus(0, 8'h42, 1'b1);
    checkOutput("t1_data_B", 32'(data), 32'h42);
    checkOutput("t1_busy_B", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(0, 8'h0A, 1'b1);
    checkOutput("t1_data_eom", 32'(data), 32'h0A);
    checkOutput("t1_busy_eom", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(0, 8'h00, 1'b0);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_grant_after", 32'(grantId), 32'd0);
    checkOutput("t1_valid_after", 32'(valid), 32'd0);

    // Test 2: all four sources request at once, two rounds
    doReset();
    for (int round = 0; round < 2; round++) begin
      for (int s = 0; s < NUM_SRC; s++) applyStimulus(s, 8'h78, 1'b1);
      for (int k = 0; k < NUM_SRC; k++) begin
        checkOutput("t2_gap_busy", 32'(busy), 32'd0);
        checkOutput("t2_gap_tready", 32'(tready), 32'd0);
        nextCycle();
        checkOutput("t2_grant", 32'(grantId), 32'(k));
        checkOutput("t2_data_x", 32'(data), 32'h78);
        checkOutput("t2_tready", 32'(tready), 32'(1 << k));
        nextCycle();
        applyStimulus(k, 8'h0A, 1'b1);
        checkOutput("t2_data_eom", 32'(data), 32'h0A);
        checkOutput("t2_busy_eom", 32'(busy), 32'd1);
        nextCycle();
        applyStimulus(k, 8'h78, 1'b0);
      end
    end

    // Test 3: source 1 message while source 2 keeps requesting
    applyStimulus(1, 8'h41, 1'b1);
    applyStimulus(2, 8'h5A, 1'b1);
    checkOutput("t3_decide_tready", 32'(tready), 32'd0);
    nextCycle();
    checkOutput("t3_grant1", 32'(grantId), 32'd1);
    checkOutput("t3_data_A", 32'(data), 32'h41);
    checkOutput("t3_tready_A", 32'(tready), 32'b0010);
    nextCycle();
    applyStimulus(1, 8'h42, 1'b1);
    checkOutput("t3_data_B", 32'(data), 32'h42);
    checkOutput("t3_tready_B", 32'(tready), 32'b0010);
    nextCycle();
    applyStimulus(1, 8'h0A, 1'b1);
    checkOutput("t3_data_eom", 32'(data), 32'h0A);
    checkOutput("t3_tready_eom", 32'(tready), 32'b0010);
    nextCycle();
    applyStimulus(1, 8'h00, 1'b0);
    checkOutput("t3_gap_busy", 32'(busy), 32'd0);
    checkOutput("t3_gap_tready", 32'(tready), 32'd0);
    nextCycle();
    checkOutput("t3_grant2", 32'(grantId), 32'd2);
    checkOutput("t3_data_Z", 32'(data), 32'h5A);
    checkOutput("t3_tready_Z", 32'(tready), 32'b0100);
    nextCycle();
    applyStimulus(2, 8'h0A, 1'b1);
    nextCycle();
    applyStimulus(2, 8'h00, 1'b0);
    checkOutput("t3_end_busy", 32'(busy), 32'd0);

    // Test 4: source 3 goes silent after one byte; source 0 waits
    applyStimulus(3, 8'h41, 1'b1);
    applyStimulus(0, 8'h51, 1'b1);
    nextCycle();
    checkOutput("t4_grant3", 32'(grantId), 32'd3);
    checkOutput("t4_data_A", 32'(data), 32'h41);
    nextCycle();
    applyStimulus(3, 8'h00, 1'b0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      checkOutput("t4_hold_busy", 32'(busy), 32'd1);
      checkOutput("t4_hold_valid", 32'(valid), 32'd0);
      checkOutput("t4_hold_tready", 32'(tready), 32'b1000);
      nextCycle();
    end
    checkOutput("t4_released", 32'(busy), 32'd0);
    checkOutput("t4_grant_kept", 32'(grantId), 32'd3);
    nextCycle();
    checkOutput("t4_grant0", 32'(grantId), 32'd0);
    checkOutput("t4_data_Q", 32'(data), 32'h51);
    nextCycle();
    applyStimulus(0, 8'h0A, 1'b1);
    nextCycle();
    applyStimulus(0, 8'h00, 1'b0);
    checkOutput("t4_end_busy", 32'(busy), 32'd0);

    // Test 5: emitter stalls for 100 cycles with source 1 valid
    ready = 1'b0;
    applyStimulus(1, 8'h4D, 1'b1);
    nextCycle();
    checkOutput("t5_grant1", 32'(grantId), 32'd1);
    for (int c = 0; c < 100; c++) begin
      checkOutput("t5_stall_busy", 32'(busy), 32'd1);
      checkOutput("t5_stall_data", 32'(data), 32'h4D);
      checkOutput("t5_stall_tready", 32'(tready), 32'd0);
      nextCycle();
    end
    ready = 1'b1;
    #1;
    checkOutput("t5_ready_tready", 32'(tready), 32'b0010);
    checkOutput("t5_ready_valid", 32'(valid), 32'd1);
    nextCycle();
    applyStimulus(1, 8'h0A, 1'b1);
    checkOutput("t5_busy_eom", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(1, 8'h00, 1'b0);
    checkOutput("t5_end_busy", 32'(busy), 32'd0);

    // Test 6: reset in the middle of a source 2 message
    applyStimulus(2, 8'h52, 1'b1);
    nextCycle();
    checkOutput("t6_grant2", 32'(grantId), 32'd2);
    nextCycle();
    applyStimulus(2, 8'h53, 1'b1);
    rst = 1'b1;
    nextCycle();
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_valid", 32'(valid), 32'd0);
    checkOutput("t6_rst_grant", 32'(grantId), 32'd3);
    checkOutput("t6_rst_tready", 32'(tready), 32'd0);
    rst = 1'b0;
    applyStimulus(0, 8'h61, 1'b1);
    nextCycle();
    checkOutput("t6_grant0", 32'(grantId), 32'd0);
    checkOutput("t6_data0", 32'(data), 32'h61);
    checkOutput("t6_tready0", 32'(tready), 32'b0001);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
